// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, vends from a price table,
// and pays change back one coin per accepted handshake.
module vend_credit_ctrl #(
    parameter  int                         N_PROD      = 4,
    parameter  int                         CREDIT_W    = 5,
    parameter  int                         MAX_CREDIT  = 20,
    parameter  logic [N_PROD*CREDIT_W-1:0] PRICE_TABLE = 20'h62061,
    parameter  bit                         AUTO_CHANGE = 1'b1,
    localparam int                         SEL_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          COIN,
    input  logic                COIN_VALID,
    input  logic [SEL_W-1:0]    SEL,
    input  logic                SEL_VALID,
    input  logic                RETURN_REQ,
    input  logic                CHANGE_READY,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                COIN_REJECT,
    output logic                VEND,
    output logic [SEL_W-1:0]    VEND_ID,
    output logic                DENY,
    output logic                CHANGE_VALID,
    output logic [1:0]          CHANGE_COIN,
    output logic                CHANGE_DONE,
    output logic                BUSY
);

    typedef enum logic {IDLE, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                vend_q, vend_d;
    logic [SEL_W-1:0]    vend_id_q, vend_id_d;
    logic                deny_q, deny_d;
    logic                done_q, done_d;

    function automatic logic [CREDIT_W-1:0] coin_val(input logic [1:0] c);
        case (c)
            2'b01:   coin_val = CREDIT_W'(1);
            2'b10:   coin_val = CREDIT_W'(2);
            2'b11:   coin_val = CREDIT_W'(5);
            default: coin_val = '0;
        endcase
    endfunction

    logic                coin_nz;
    logic [CREDIT_W:0]   sum;
    logic                sel_ok;
    logic [CREDIT_W-1:0] price;
    logic [1:0]          chg_coin;

    // Change coin depends only on registered credit, never on inputs.
    always_comb begin
        if (credit_q >= CREDIT_W'(5))      chg_coin = 2'b11;
        else if (credit_q >= CREDIT_W'(2)) chg_coin = 2'b10;
        else                               chg_coin = 2'b01;
    end

    always_comb begin
        price = '0;
        for (int i = 0; i < N_PROD; i++)
            if (SEL == SEL_W'(i)) price = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
    end

    assign coin_nz = COIN_VALID && (COIN != 2'b00);
    // One extra bit so credit + coin cannot wrap before the limit check.
    assign sum     = {1'b0, credit_q} + {1'b0, coin_val(COIN)};
    assign sel_ok  = int'(SEL) < N_PROD;

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        reject_d  = 1'b0;
        vend_d    = 1'b0;
        vend_id_d = '0;
        deny_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RETURN_REQ) begin
                    reject_d = coin_nz;
                    if (credit_q != '0) state_d = CHANGE;
                end else if (SEL_VALID) begin
                    reject_d = coin_nz;
                    if (!sel_ok || credit_q < price) begin
                        deny_d = 1'b1;
                    end else begin
                        vend_d    = 1'b1;
                        vend_id_d = SEL;
                        credit_d  = credit_q - price;
                        if (AUTO_CHANGE && credit_d != '0) state_d = CHANGE;
                    end
                end else if (coin_nz) begin
                    if (sum > (CREDIT_W+1)'(MAX_CREDIT)) reject_d = 1'b1;
                    else                                 credit_d = sum[CREDIT_W-1:0];
                end
            end
            CHANGE: begin
                reject_d = coin_nz;
                if (CHANGE_READY) begin
                    credit_d = credit_q - coin_val(chg_coin);
                    if (credit_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            credit_q  <= '0;
            reject_q  <= 1'b0;
            vend_q    <= 1'b0;
            vend_id_q <= '0;
            deny_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            reject_q  <= reject_d;
            vend_q    <= vend_d;
            vend_id_q <= vend_id_d;
            deny_q    <= deny_d;
            done_q    <= done_d;
        end
    end

    assign CREDIT       = credit_q;
    assign COIN_REJECT  = reject_q;
    assign VEND         = vend_q;
    assign VEND_ID      = vend_id_q;
    assign DENY         = deny_q;
    assign CHANGE_VALID = (state_q == CHANGE);
    assign CHANGE_COIN  = CHANGE_VALID ? chg_coin : 2'b00;
    assign CHANGE_DONE  = done_q;
    assign BUSY         = (state_q == CHANGE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench: per-cycle vector table for the default controller plus
// hand sequences for reset mid-change and the keep-remainder variant.
module tb_vend_credit_ctrl;

    logic       CLK = 1'b0;
    logic       RST, COIN_VALID, SEL_VALID, RETURN_REQ, CHANGE_READY;
    logic [1:0] COIN, SEL;

    logic [4:0] cr0, cr1;
    logic       rej0, vend0, deny0, chv0, done0, busy0;
    logic       rej1, vend1, deny1, chv1, done1, busy1;
    logic [1:0] vid0, chc0, vid1, chc1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    vend_credit_ctrl u0 (
        .CLK(CLK), .RST(RST), .COIN(COIN), .COIN_VALID(COIN_VALID), .SEL(SEL),
        .SEL_VALID(SEL_VALID), .RETURN_REQ(RETURN_REQ), .CHANGE_READY(CHANGE_READY),
        .CREDIT(cr0), .COIN_REJECT(rej0), .VEND(vend0), .VEND_ID(vid0), .DENY(deny0),
        .CHANGE_VALID(chv0), .CHANGE_COIN(chc0), .CHANGE_DONE(done0), .BUSY(busy0));

    vend_credit_ctrl #(.AUTO_CHANGE(1'b0)) u1 (
        .CLK(CLK), .RST(RST), .COIN(COIN), .COIN_VALID(COIN_VALID), .SEL(SEL),
        .SEL_VALID(SEL_VALID), .RETURN_REQ(RETURN_REQ), .CHANGE_READY(CHANGE_READY),
        .CREDIT(cr1), .COIN_REJECT(rej1), .VEND(vend1), .VEND_ID(vid1), .DENY(deny1),
        .CHANGE_VALID(chv1), .CHANGE_COIN(chc1), .CHANGE_DONE(done1), .BUSY(busy1));

    // Outputs packed as {credit, reject, vend, vend_id, deny, chg_valid, chg_coin, done, busy}
    typedef struct packed {
        logic       rst, cv;
        logic [1:0] coin;
        logic       sv;
        logic [1:0] sel;
        logic       rr, rdy;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [14:0] o(input int cr, rej, vd, vid, dn, chv, chc, dne, bsy);
        return {5'(cr), 1'(rej), 1'(vd), 2'(vid), 1'(dn), 1'(chv), 2'(chc), 1'(dne), 1'(bsy)};
    endfunction

    function automatic void v(input int rst, cv, coin, sv, sel, rr, rdy, input logic [14:0] e);
        vec_t r;
        r = '{rst: 1'(rst), cv: 1'(cv), coin: 2'(coin), sv: 1'(sv), sel: 2'(sel),
              rr: 1'(rr), rdy: 1'(rdy), exp: e};
        tbl.push_back(r);
    endfunction

    task automatic step(input int rst, cv, coin, sv, sel, rr, rdy);
        @(negedge CLK);
        RST = 1'(rst); COIN_VALID = 1'(cv); COIN = 2'(coin); SEL_VALID = 1'(sv);
        SEL = 2'(sel); RETURN_REQ = 1'(rr); CHANGE_READY = 1'(rdy);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] out0();
        return {cr0, rej0, vend0, vid0, deny0, chv0, chc0, done0, busy0};
    endfunction

    function automatic logic [14:0] out1();
        return {cr1, rej1, vend1, vid1, deny1, chv1, chc1, done1, busy1};
    endfunction

    initial begin
        RST = 1'b1; COIN_VALID = 0; COIN = 0; SEL_VALID = 0; SEL = 0;
        RETURN_REQ = 0; CHANGE_READY = 0;

        //   rst cv coin sv sel rr rdy   cr rej vd vid dn chv chc dne bsy
        v(1, 0, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 2, 0, 0, 0, 1, o( 2, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 1, 0, 0, 0, 1, o( 3, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 0, 0, 1, 1, 0, 1, o( 0, 0, 1, 1, 0, 0, 0, 0, 0));
        v(0, 0, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 3, 0, 0, 0, 1, o( 5, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 3, 0, 0, 0, 1, o(10, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 2, 0, 0, 0, 1, o(12, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 0, 0, 1, 2, 0, 1, o( 4, 0, 1, 2, 0, 1, 2, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 2, 0, 0, 0, 0, 1, 2, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 1, 0));
        v(0, 0, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 1, 0, 0, 0, 1, o( 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 2, 0, 0, 0, 1, o( 3, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 0, 0, 1, 3, 0, 1, o( 3, 0, 0, 0, 1, 0, 0, 0, 0));
        v(0, 0, 0, 0, 0, 1, 0, o( 3, 0, 0, 0, 0, 1, 2, 0, 1));
        v(0, 0, 0, 1, 0, 1, 0, o( 3, 0, 0, 0, 0, 1, 2, 0, 1));
        v(0, 0, 0, 0, 0, 0, 0, o( 3, 0, 0, 0, 0, 1, 2, 0, 1));
        v(0, 0, 0, 0, 0, 0, 0, o( 3, 0, 0, 0, 0, 1, 2, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 1, 0, 0, 0, 0, 1, 1, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 1, 0));
        v(0, 1, 3, 0, 0, 0, 1, o( 5, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 3, 0, 0, 0, 1, o(10, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 3, 0, 0, 0, 1, o(15, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 2, 0, 0, 0, 1, o(17, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 1, 0, 0, 0, 1, o(18, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 3, 0, 0, 0, 1, o(18, 1, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 2, 0, 0, 0, 1, o(20, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 1, 0, 0, 0, 1, o(20, 1, 0, 0, 0, 0, 0, 0, 0));
        v(0, 1, 2, 1, 3, 0, 1, o( 8, 1, 1, 3, 0, 1, 3, 0, 1));
        v(0, 1, 2, 0, 0, 0, 0, o( 8, 1, 0, 0, 0, 1, 3, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 3, 0, 0, 0, 0, 1, 2, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 1, 0, 0, 0, 0, 1, 1, 0, 1));
        v(0, 0, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 1, 0));
        v(0, 1, 1, 1, 0, 0, 1, o( 0, 1, 0, 0, 1, 0, 0, 0, 0));
        v(0, 1, 0, 0, 0, 0, 1, o( 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v(0, 0, 0, 0, 0, 1, 1, o( 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].cv, tbl[i].coin, tbl[i].sv, tbl[i].sel, tbl[i].rr, tbl[i].rdy);
            chk($sformatf("vec%0d", i), out0(), tbl[i].exp);
        end

        // Reset while paying change on credit 7
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("rst_mid_pre", out0(), o(7, 0, 0, 0, 0, 1, 3, 0, 1));
        step(1, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_u0", out0(), o(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_mid_u1", out1(), o(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_after", out0(), o(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Keep-remainder variant: credit 7, buy product 1 (price 3)
        step(0, 1, 3, 0, 0, 0, 1);
        step(0, 1, 2, 0, 0, 0, 1);
        chk("keep_credit7", out1(), o(7, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 1, 1, 0, 1);
        chk("keep_vend", out1(), o(4, 0, 1, 1, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 1);
        chk("keep_hold", out1(), o(4, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 1, 0);
        chk("keep_return", out1(), o(4, 0, 0, 0, 0, 1, 2, 0, 1));
        step(1, 0, 0, 0, 0, 0, 0);
        chk("keep_rst", out1(), o(0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
